// File: rtl/tick_counter_if.sv
// Control and status bundle for tick_counter: run controls in, count/strobes/state out.
interface tick_counter_if #(
   parameter int MODULO = 10
);
   localparam int CW = (MODULO > 2) ? $clog2(MODULO) : 1;

   logic          start;
   logic          stop;
   logic          clr;
   logic          dir;
   logic          oneshot;
   logic [CW-1:0] count;
   logic [MODULO-1:0] led;
   logic          tick;
   logic          wrap;
   logic          running;
   logic          done;

   modport master (
      output start, stop, clr, dir, oneshot,
      input  count, led, tick, wrap, running, done
   );

   modport slave (
      input  start, stop, clr, dir, oneshot,
      output count, led, tick, wrap, running, done
   );
endinterface

// File: rtl/tick_counter.sv
// Two-stage prescaled up/down modulo counter with one-hot decode and
// IDLE/RUN/PAUSE/DONE sequencing.
module tick_counter #(
   parameter int PRE1   = 50000,
   parameter int PRE2   = 100,
   parameter int MODULO = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   tick_counter_if.slave bus
);
   localparam int CW  = (MODULO > 2) ? $clog2(MODULO) : 1;
   localparam int P1W = $clog2(PRE1);
   localparam int P2W = $clog2(PRE2);

   localparam logic [P1W-1:0] P1_LAST = P1W'(PRE1 - 32'sd1);
   localparam logic [P2W-1:0] P2_LAST = P2W'(PRE2 - 32'sd1);
   localparam logic [CW-1:0]  C_LAST  = CW'(MODULO - 32'sd1);
   localparam logic [P1W-1:0] P1_ZERO = {P1W{1'b0}};
   localparam logic [P2W-1:0] P2_ZERO = {P2W{1'b0}};
   localparam logic [CW-1:0]  C_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0]  C_ONE   = CW'(1'b1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state_r, state_nxt_s;
   logic [P1W-1:0]    p1_r, p1_nxt_s;
   logic [P2W-1:0]    p2_r, p2_nxt_s;
   logic [CW-1:0]     count_r, count_nxt_s;
   logic [MODULO-1:0] led_r;
   logic              tick_s;
   logic              wrap_s;
   logic              term_s;
   logic [CW-1:0]     reload_s;

   function automatic logic [MODULO-1:0] onehot(input logic [CW-1:0] v);
      logic [MODULO-1:0] r;
      for (int i = 0; i < MODULO; i++) begin
         r[i] = (v == CW'(i));
      end
      return r;
   endfunction

   // Strobes and terminal detection derived from the current state and controls
   always_comb begin
      tick_s   = (state_r == RUN) && (p1_r == P1_LAST) && (p2_r == P2_LAST)
                 && !bus.stop && !bus.clr;
      term_s   = bus.dir ? (count_r == C_LAST) : (count_r == C_ZERO);
      wrap_s   = tick_s && term_s;
      reload_s = bus.dir ? C_ZERO : C_LAST;
   end

   // Next-state, prescaler and count update; clr beats stop beats start
   always_comb begin
      state_nxt_s = state_r;
      p1_nxt_s    = p1_r;
      p2_nxt_s    = p2_r;
      count_nxt_s = count_r;
      if (bus.clr) begin
         state_nxt_s = IDLE;
         p1_nxt_s    = P1_ZERO;
         p2_nxt_s    = P2_ZERO;
         count_nxt_s = C_ZERO;
      end else begin
         case (state_r)
            IDLE: begin
               if (!bus.stop && bus.start) begin
                  state_nxt_s = RUN;
                  p1_nxt_s    = P1_ZERO;
                  p2_nxt_s    = P2_ZERO;
                  count_nxt_s = reload_s;
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            RUN: begin
               if (bus.stop) begin
                  state_nxt_s = PAUSE;
               end else begin
                  // Second stage only moves on the first stage's terminal count
                  if (p1_r == P1_LAST) begin
                     p1_nxt_s = P1_ZERO;
                     p2_nxt_s = (p2_r == P2_LAST) ? P2_ZERO : (p2_r + P2W'(1'b1));
                  end else begin
                     p1_nxt_s = p1_r + P1W'(1'b1);
                  end
                  if (wrap_s && bus.oneshot) begin
                     state_nxt_s = DONE;
                  end else if (tick_s) begin
                     if (bus.dir) begin
                        count_nxt_s = term_s ? C_ZERO : (count_r + C_ONE);
                     end else begin
                        count_nxt_s = term_s ? C_LAST : (count_r - C_ONE);
                     end
                  end else begin
                     count_nxt_s = count_r;
                  end
               end
            end
            PAUSE: begin
               if (!bus.stop && bus.start) begin
                  state_nxt_s = RUN;
               end else begin
                  state_nxt_s = PAUSE;
               end
            end
            DONE: begin
               // stop carries no meaning once finished, so it cannot block a restart
               if (bus.start) begin
                  state_nxt_s = RUN;
                  p1_nxt_s    = P1_ZERO;
                  p2_nxt_s    = P2_ZERO;
                  count_nxt_s = reload_s;
               end else begin
                  state_nxt_s = DONE;
               end
            end
            default: begin
               state_nxt_s = IDLE;
               p1_nxt_s    = P1_ZERO;
               p2_nxt_s    = P2_ZERO;
               count_nxt_s = C_ZERO;
            end
         endcase
      end
   end

   // State, prescaler, count and decoded led registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         p1_r    <= P1_ZERO;
         p2_r    <= P2_ZERO;
         count_r <= C_ZERO;
         led_r   <= onehot(C_ZERO);
      end else begin
         state_r <= state_nxt_s;
         p1_r    <= p1_nxt_s;
         p2_r    <= p2_nxt_s;
         count_r <= count_nxt_s;
         led_r   <= onehot(count_nxt_s);
      end
   end

   assign bus.count   = count_r;
   assign bus.led     = led_r;
   assign bus.tick    = tick_s;
   assign bus.wrap    = wrap_s;
   assign bus.running = (state_r == RUN);
   assign bus.done    = (state_r == DONE);
endmodule

// File: tb/tb_tick_counter.sv
// Directed bench for tick_counter: main instance PRE1=4/PRE2=3/MODULO=10,
// second instance PRE1=2/PRE2=2/MODULO=2.
module tb_tick_counter;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   tick_counter_if #(.MODULO(10)) bus_a ();
   tick_counter_if #(.MODULO(2))  bus_b ();

   tick_counter #(.PRE1(4), .PRE2(3), .MODULO(10)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a.slave)
   );

   tick_counter #(.PRE1(2), .PRE2(2), .MODULO(2)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Waits for a tick on the chosen instance and checks how many cycles it took
   task automatic wait_tick(input bit sel_b, input int exp, input string tag);
      int n;
      n = 0;
      do begin
         cyc(1);
         n++;
      end while (((sel_b ? bus_b.tick : bus_a.tick) !== 1'b1) && (n < 200));
      chk(tag, n, exp);
   endtask

   initial begin
      int nt;
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.clr = 1'b0;
      bus_a.dir = 1'b1;   bus_a.oneshot = 1'b0;
      bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.clr = 1'b0;
      bus_b.dir = 1'b1;   bus_b.oneshot = 1'b0;

      // reset state
      cyc(2);
      chk("rst_count", bus_a.count, 0);
      chk("rst_led", bus_a.led, 10'h001);
      chk("rst_running", bus_a.running, 0);
      chk("rst_done", bus_a.done, 0);
      chk("rst_tick", bus_a.tick, 0);
      chk("rst_wrap", bus_a.wrap, 0);
      rst_n = 1'b1;
      cyc(3);
      chk("idle_after_rst", bus_a.running, 0);

      // up count, continuous wrap
      bus_a.start = 1'b1; cyc(1); bus_a.start = 1'b0;
      chk("up_running", bus_a.running, 1);
      chk("up_load", bus_a.count, 0);
      for (int i = 0; i < 10; i++) begin
         wait_tick(1'b0, (i == 0) ? 11 : 12, "up_period");
         chk("up_count", bus_a.count, i);
         chk("up_led", bus_a.led, 32'd1 << i);
         chk("up_wrap", bus_a.wrap, (i == 9) ? 1 : 0);
      end
      cyc(1);
      chk("up_rollover", bus_a.count, 0);
      chk("up_rollover_led", bus_a.led, 10'h001);

      // down count
      bus_a.clr = 1'b1; cyc(1); bus_a.clr = 1'b0;
      bus_a.dir = 1'b0; bus_a.start = 1'b1; cyc(1); bus_a.start = 1'b0;
      chk("dn_load", bus_a.count, 9);
      wait_tick(1'b0, 11, "dn_first");
      chk("dn_first_wrap", bus_a.wrap, 0);
      for (int i = 8; i >= 0; i--) begin
         wait_tick(1'b0, 12, "dn_period");
         chk("dn_count", bus_a.count, i);
         chk("dn_wrap", bus_a.wrap, (i == 0) ? 1 : 0);
      end
      cyc(1);
      chk("dn_rollover", bus_a.count, 9);

      // oneshot
      bus_a.clr = 1'b1; cyc(1); bus_a.clr = 1'b0;
      bus_a.dir = 1'b1; bus_a.oneshot = 1'b1;
      bus_a.start = 1'b1; cyc(1); bus_a.start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         wait_tick(1'b0, (i == 0) ? 11 : 12, "os_period");
         chk("os_count", bus_a.count, i);
      end
      chk("os_wrap", bus_a.wrap, 1);
      cyc(1);
      chk("os_done", bus_a.done, 1);
      chk("os_running", bus_a.running, 0);
      chk("os_hold", bus_a.count, 9);
      nt = 0;
      for (int i = 0; i < 30; i++) begin
         cyc(1);
         if (bus_a.tick === 1'b1) nt++;
      end
      chk("os_no_ticks", nt, 0);
      bus_a.oneshot = 1'b0; bus_a.stop = 1'b1; bus_a.start = 1'b1; cyc(1);
      bus_a.start = 1'b0; bus_a.stop = 1'b0;
      chk("os_restart_count", bus_a.count, 0);
      chk("os_restart_running", bus_a.running, 1);
      chk("os_restart_done", bus_a.done, 0);

      // pause with first prescaler at 2, then resume
      cyc(2);
      bus_a.stop = 1'b1; cyc(1); bus_a.stop = 1'b0;
      chk("pause_running", bus_a.running, 0);
      nt = 0;
      for (int i = 0; i < 50; i++) begin
         cyc(1);
         if (bus_a.tick === 1'b1) nt++;
      end
      chk("pause_no_ticks", nt, 0);
      chk("pause_hold", bus_a.count, 0);
      bus_a.start = 1'b1; cyc(1); bus_a.start = 1'b0;
      chk("resume_running", bus_a.running, 1);
      wait_tick(1'b0, 9, "resume_latency");
      chk("resume_count", bus_a.count, 0);
      bus_a.start = 1'b1; bus_a.stop = 1'b1; cyc(1);
      bus_a.start = 1'b0; bus_a.stop = 1'b0;
      chk("start_stop_pause", bus_a.running, 0);
      chk("start_stop_done", bus_a.done, 0);

      // synchronous clear at count 5
      bus_a.clr = 1'b1; cyc(1); bus_a.clr = 1'b0;
      bus_a.start = 1'b1; cyc(1); bus_a.start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         wait_tick(1'b0, (i == 0) ? 11 : 12, "clr_period");
      end
      cyc(1);
      chk("clr_pre_count", bus_a.count, 5);
      bus_a.clr = 1'b1; cyc(1); bus_a.clr = 1'b0;
      chk("clr_running", bus_a.running, 0);
      chk("clr_count", bus_a.count, 0);
      chk("clr_led", bus_a.led, 10'h001);
      cyc(5);
      chk("clr_stays_idle", bus_a.running, 0);

      // asynchronous reset mid-run
      bus_a.dir = 1'b0; bus_a.start = 1'b1; cyc(1); bus_a.start = 1'b0;
      chk("arst_pre_count", bus_a.count, 9);
      rst_n = 1'b0;
      #1;
      chk("arst_count", bus_a.count, 0);
      chk("arst_led", bus_a.led, 10'h001);
      chk("arst_running", bus_a.running, 0);
      cyc(1);
      rst_n = 1'b1;
      cyc(1);
      bus_a.dir = 1'b1;

      // minimal configuration instance
      bus_b.start = 1'b1; cyc(1); bus_b.start = 1'b0;
      chk("b_load", bus_b.count, 0);
      wait_tick(1'b1, 3, "b_first");
      chk("b_count0", bus_b.count, 0);
      chk("b_wrap0", bus_b.wrap, 0);
      wait_tick(1'b1, 4, "b_period1");
      chk("b_count1", bus_b.count, 1);
      chk("b_wrap1", bus_b.wrap, 1);
      wait_tick(1'b1, 4, "b_period2");
      chk("b_count2", bus_b.count, 0);
      chk("b_led2", bus_b.led, 2'b01);
      cyc(1);
      chk("b_toggle", bus_b.count, 1);
      chk("b_led_toggle", bus_b.led, 2'b10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/tick_counter.md
TICK_COUNTER -- requirements
Module: tick_counter

Interface
REQ-001 SHALL have parameter PRE1, default 50000, meaning first prescaler divide ratio (>=2).
REQ-002 SHALL have parameter PRE2, default 100, meaning second prescaler divide ratio (>=2), counting only on first-stage terminal.
REQ-003 SHALL have parameter MODULO, default 10, meaning count modulus (2..64); CW = clog2(MODULO), minimum 1.
REQ-004 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start  input  1  begin or resume counting (level, sampled each clk).
REQ-007 SHALL have port stop  input  1  pause counting.
REQ-008 SHALL have port clr  input  1  synchronous clear to IDLE.
REQ-009 SHALL have port dir  input  1  1 = up, 0 = down.
REQ-010 SHALL have port oneshot  input  1  1 = halt at terminal count, 0 = wrap continuously.
REQ-011 SHALL have port count  output  CW  current count value.
REQ-012 SHALL have port led  output  MODULO  one-hot decode of count.
REQ-013 SHALL have port tick  output  1  one-cycle count-advance strobe.
REQ-014 SHALL have port wrap  output  1  one-cycle terminal-count strobe.
REQ-015 SHALL have port running  output  1  high in state RUN.
REQ-016 SHALL have port done  output  1  high in state DONE.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, PAUSE, DONE.
REQ-018 Priority per cycle SHALL be: clr > stop > start > tick.
REQ-019 clr in any state SHALL go to IDLE with both prescalers and count = 0.
REQ-020 IDLE: start -> RUN, both prescalers to 0, count loaded with 0 (dir=1) or MODULO-1 (dir=0).
REQ-021 RUN: stop -> PAUSE; prescalers and count hold.
REQ-022 PAUSE: start -> RUN, resuming from held prescaler and count values (no reload).
REQ-023 DONE: start -> RUN with the same reload as REQ-020; stop in DONE ignored.
REQ-024 Prescaler 1 SHALL count 0..PRE1-1 and wrap, only in RUN; prescaler 2 SHALL advance 0..PRE2-1 only when prescaler 1 = PRE1-1.
REQ-025 tick SHALL be combinational: RUN and prescaler1 = PRE1-1 and prescaler2 = PRE2-1 and not stop and not clr.
REQ-026 First tick after entry to RUN from IDLE/DONE SHALL occur PRE1*PRE2 cycles after the start cycle; period thereafter PRE1*PRE2.
REQ-027 On tick, dir=1: count SHALL increment, MODULO-1 -> 0 wrap; dir=0: decrement, 0 -> MODULO-1 wrap; update takes effect the cycle after tick.
REQ-028 wrap SHALL equal tick and count at terminal (MODULO-1 if dir=1, 0 if dir=0).
REQ-029 dir changes SHALL take effect on the next tick; no reload.
REQ-030 oneshot=1 on a wrap cycle: count SHALL hold terminal value, state -> DONE; wrap still pulses once.
REQ-031 led[i] SHALL be 1 iff count = i; exactly one bit high at all times.

Reset
REQ-032 rst_n=0 SHALL immediately force IDLE, prescalers = 0, count = 0, led = 1 (bit 0), tick = wrap = running = done = 0.
REQ-033 Release of rst_n SHALL not itself start counting; start is required.

Verification (PRE1=4, PRE2=3, MODULO=10 unless stated)
REQ-034 start 1 cycle, dir=1, oneshot=0 -> running=1; tick every 12 cycles; count 0,1..9,0; wrap only on 9->0 tick; led one-hot tracks count.
REQ-035 dir=0 start -> count loads 9; decrements each tick; wrap on 0 tick; count -> 9.
REQ-036 oneshot=1, dir=1, run to count 9 -> wrap pulses once, done=1, count holds 9, no further ticks; start -> count 0, running=1.
REQ-037 stop at prescaler1=2 -> PAUSE, no ticks for 50 cycles; start -> next tick exactly after remaining prescaler cycles; start and stop together in RUN -> PAUSE.
REQ-038 clr in RUN at count 5 -> next cycle IDLE, count 0, led = 1; rst_n low mid-RUN -> outputs at reset values same cycle, asynchronously.
REQ-039 MODULO=2, PRE1=2, PRE2=2 -> CW=1, count toggles every 4 cycles, wrap on every 1->0 tick.
